debounce_multi: RTL and testbench



---
 rtl/debounce_pkg.sv | 25 ++
 rtl/debounce_chan.sv | 76 +++++++
 rtl/debounce_multi.sv | 54 +++++
 tb/tb_debounce_multi.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and elaboration helpers for the multi-channel debouncer.
package debounce_pkg;

  localparam int DWELL_W = 20;

  typedef logic [DWELL_W-1:0] dwell_t;

  // Debounced level of one channel; the encoding equals sig_out.
  typedef enum logic {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } chan_state_t;

  function automatic dwell_t max_dwell(input dwell_t a, input dwell_t b);
    return (a > b) ? a : b;
  endfunction

  // Width that can hold every value 0..max(a,b); never below 1.
  function automatic int cnt_width(input dwell_t a, input dwell_t b);
    int w;
    w = $clog2(int'(max_dwell(a, b)) + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: synchroniser, dwell counter, level state and edge pulses.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter dwell_t DWELL_RISE  = 20'd1000,
  parameter dwell_t DWELL_FALL  = 20'd1000,
  parameter int     SYNC_STAGES = 2,
  parameter logic   RESET_VAL   = 1'b0,
  parameter int     CNT_W       = cnt_width(DWELL_RISE, DWELL_FALL)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic sig_out,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_sync;
  chan_state_t            state_q;
  logic [CNT_W-1:0]       cnt_q;
  dwell_t                 target;
  logic                   mismatch;
  logic                   expire;

  // NOTE: the synchroniser is reset to RESET_VAL, not 0, so a channel whose
  // board default is high does not see a false mismatch after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
    end
  end

  assign s_sync   = sync_q[SYNC_STAGES-1];
  assign target   = (state_q == ST_LOW) ? DWELL_RISE : DWELL_FALL;
  assign mismatch = (s_sync != (state_q == ST_HIGH));
  assign expire   = (dwell_t'(cnt_q) == (target - dwell_t'(1)));

  // NOTE: all state here is sequential, so every assignment is non-blocking;
  // the pulses default low each cycle so they can only last one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_VAL ? ST_HIGH : ST_LOW;
      cnt_q   <= '0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (!mismatch) begin
        cnt_q <= '0;
      end else if (expire) begin
        cnt_q <= '0;
        case (state_q)
          ST_LOW: begin
            state_q <= ST_HIGH;
            rise    <= 1'b1;
          end
          default: begin
            state_q <= ST_LOW;
            fall    <= 1'b1;
          end
        endcase
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // The state register itself is the debounced level.
  assign sig_out = (state_q == ST_HIGH);

endmodule

// File: rtl/debounce_multi.sv
// N-channel debouncer: per-channel debounce_chan instances plus a sticky pending vector.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int            N_CH        = 8,
  parameter dwell_t        DWELL_RISE  = 20'd1000,
  parameter dwell_t        DWELL_FALL  = 20'd1000,
  parameter int            SYNC_STAGES = 2,
  parameter logic [N_CH-1:0] RESET_VAL = {N_CH{1'b0}}
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] sig_in,
  output logic [N_CH-1:0] sig_out,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] pending,
  input  logic [N_CH-1:0] pend_clr
);

  localparam int CNT_W = cnt_width(DWELL_RISE, DWELL_FALL);

  if (DWELL_RISE == '0 || DWELL_FALL == '0 || SYNC_STAGES < 2 || N_CH < 1 || N_CH > 32)
  begin : g_bad_params
    $fatal(1, "debounce_multi: illegal parameters (dwell 0, SYNC_STAGES<2 or N_CH outside 1..32)");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    debounce_chan #(
      .DWELL_RISE  (DWELL_RISE),
      .DWELL_FALL  (DWELL_FALL),
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_VAL   (RESET_VAL[i]),
      .CNT_W       (CNT_W)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .sig_in  (sig_in[i]),
      .sig_out (sig_out[i]),
      .rise    (rise[i]),
      .fall    (fall[i])
    );
  end

  // A new event in the same cycle as a clear keeps the bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~pend_clr) | rise | fall;
    end
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Scenario and randomised bench for debounce_multi against a run-length reference model.
module tb_debounce_multi;

  localparam int          N    = 4;
  localparam int          DR   = 4;
  localparam int          DF   = 2;
  localparam int          SYNC = 2;
  localparam logic [N-1:0] RV  = 4'b0010;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] sig_in;
  logic [N-1:0] pend_clr;
  logic [N-1:0] sig_out;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic [N-1:0] pending;

  int checks = 0;
  int errors = 0;

  debounce_multi #(
    .N_CH        (N),
    .DWELL_RISE  (20'(DR)),
    .DWELL_FALL  (20'(DF)),
    .SYNC_STAGES (SYNC),
    .RESET_VAL   (RV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sig_in   (sig_in),
    .sig_out  (sig_out),
    .rise     (rise),
    .fall     (fall),
    .pending  (pending),
    .pend_clr (pend_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: input history delayed SYNC edges, then the output flips
  // once the delayed input has disagreed with it for a full dwell run.
  logic [N-1:0] m_hist [SYNC];
  int           m_run  [N];
  logic [N-1:0] m_out, m_rise, m_fall, m_pend;

  function automatic int dwell_of(input logic level);
    return level ? DF : DR;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC; k++) m_hist[k] <= RV;
      for (int i = 0; i < N; i++) m_run[i] <= 0;
      m_out  <= RV;
      m_rise <= '0;
      m_fall <= '0;
      m_pend <= '0;
    end else begin
      m_hist[0] <= sig_in;
      for (int k = 1; k < SYNC; k++) m_hist[k] <= m_hist[k-1];
      m_pend <= (m_pend & ~pend_clr) | m_rise | m_fall;
      for (int i = 0; i < N; i++) begin
        m_rise[i] <= 1'b0;
        m_fall[i] <= 1'b0;
        if (m_hist[SYNC-1][i] === m_out[i]) begin
          m_run[i] <= 0;
        end else if (m_run[i] + 1 >= dwell_of(m_out[i])) begin
          m_out[i]  <= ~m_out[i];
          m_run[i]  <= 0;
          m_rise[i] <= ~m_out[i];
          m_fall[i] <= m_out[i];
        end else begin
          m_run[i] <= m_run[i] + 1;
        end
      end
    end
  end

  task automatic test_reset();
    sig_in   = RV;
    pend_clr = '0;
    rst_n    = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sig_out, rise, fall, pending} !== {RV, 12'h000}) begin
      errors++;
      $display("FAIL reset_assert: out=%b r=%b f=%b p=%b want out=%b r=f=p=0", sig_out, rise, fall, pending, RV);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checks++;
      if ({sig_out, rise, fall, pending} !== {RV, 12'h000}) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: out=%b r=%b f=%b p=%b want out=%b r=f=p=0", k, sig_out, rise, fall, pending, RV);
      end
    end
  endtask

  task automatic test_clean_rise();
    sig_in[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checks++;
      if ({sig_out, rise, fall, pending} !== {m_out, m_rise, m_fall, m_pend}) begin
        errors++;
        $display("FAIL clean_rise_model cyc %0d: out=%b r=%b f=%b p=%b want %b %b %b %b", k, sig_out, rise, fall, pending, m_out, m_rise, m_fall, m_pend);
      end
      checks++;
      if ({sig_out[0], rise[0], pending[0]} !== {(k >= 6), (k == 6), (k >= 7)}) begin
        errors++;
        $display("FAIL clean_rise cyc %0d: out0=%b rise0=%b pend0=%b want %b %b %b", k, sig_out[0], rise[0], pending[0], (k >= 6), (k == 6), (k >= 7));
      end
    end
  endtask

  task automatic test_glitch();
    sig_in[2] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 3) sig_in[2] = 1'b0;
      checks++;
      if ({sig_out[2], rise[2], pending[2]} !== 3'b000 || sig_out !== m_out) begin
        errors++;
        $display("FAIL glitch_reject cyc %0d: out=%b rise2=%b pend2=%b want out=%b rise2=0 pend2=0", k, sig_out, rise[2], pending[2], m_out);
      end
    end
    sig_in[2] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if ({sig_out[2], rise[2]} !== {(k >= 6), (k == 6)} || {rise, fall, pending} !== {m_rise, m_fall, m_pend}) begin
        errors++;
        $display("FAIL glitch_then_rise cyc %0d: out2=%b rise2=%b p=%b want %b %b p=%b", k, sig_out[2], rise[2], pending, (k >= 6), (k == 6), m_pend);
      end
    end
  endtask

  task automatic test_bounce_fall();
    int n_fall = 0;
    int n_rise = 0;
    for (int j = 0; j < 10; j++) begin
      sig_in[1] = j[0];
      @(negedge clk);
      n_fall += int'(fall[1]);
      n_rise += int'(rise[1]);
    end
    sig_in[1] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_fall += int'(fall[1]);
      n_rise += int'(rise[1]);
      checks++;
      if ({sig_out[1], fall[1]} !== {(k < 4), (k == 4)} || sig_out !== m_out) begin
        errors++;
        $display("FAIL bounce_fall cyc %0d: out1=%b fall1=%b want %b %b (out=%b model=%b)", k, sig_out[1], fall[1], (k < 4), (k == 4), sig_out, m_out);
      end
    end
    checks++;
    if (n_fall != 1 || n_rise != 0) begin
      errors++;
      $display("FAIL bounce_count: fall1 pulses=%0d rise1 pulses=%0d want 1 and 0", n_fall, n_rise);
    end
  endtask

  task automatic test_pending_race();
    @(negedge clk);
    pend_clr = 4'b1111;
    @(negedge clk);
    pend_clr = 4'b0000;
    checks++;
    if (pending !== 4'b0000) begin
      errors++;
      $display("FAIL pend_clear_all: pending=%b want 0000", pending);
    end
    sig_in[0] = 1'b0;
    sig_in[3] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 6) begin
        checks++;
        if ({rise[3], pending} !== {1'b1, 4'b0001}) begin
          errors++;
          $display("FAIL pend_race_setup: rise3=%b pending=%b want 1 0001", rise[3], pending);
        end
        pend_clr = 4'b1001;
      end else begin
        pend_clr = 4'b0000;
      end
      if (k == 7) begin
        checks++;
        if (pending !== 4'b1000) begin
          errors++;
          $display("FAIL pend_race: pending=%b want 1000", pending);
        end
      end
      checks++;
      if ({sig_out, rise, fall, pending} !== {m_out, m_rise, m_fall, m_pend}) begin
        errors++;
        $display("FAIL pend_race_model cyc %0d: out=%b r=%b f=%b p=%b want %b %b %b %b", k, sig_out, rise, fall, pending, m_out, m_rise, m_fall, m_pend);
      end
    end
    pend_clr = 4'b0000;
  endtask

  task automatic test_reset_mid_count();
    sig_in[0] = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sig_out, rise, fall, pending} !== {RV, 12'h000}) begin
      errors++;
      $display("FAIL reset_mid_count: out=%b r=%b f=%b p=%b want out=%b r=f=p=0", sig_out, rise, fall, pending, RV);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if ({sig_out[0], rise[0]} !== {(k >= 6), (k == 6)} || {sig_out, rise, fall, pending} !== {m_out, m_rise, m_fall, m_pend}) begin
        errors++;
        $display("FAIL reset_rerun cyc %0d: out=%b r=%b f=%b p=%b want %b %b %b %b", k, sig_out, rise, fall, pending, m_out, m_rise, m_fall, m_pend);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] flip;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      checks++;
      if ({sig_out, rise, fall, pending} !== {m_out, m_rise, m_fall, m_pend} || (rise & fall) !== '0) begin
        errors++;
        $display("FAIL random cyc %0d: out=%b r=%b f=%b p=%b want %b %b %b %b", k, sig_out, rise, fall, pending, m_out, m_rise, m_fall, m_pend);
      end
      flip = '0;
      for (int i = 0; i < N; i++) flip[i] = ($urandom_range(0, 5) == 0);
      sig_in   = sig_in ^ flip;
      pend_clr = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
    end
  endtask

  initial begin
    test_reset();
    test_clean_rise();
    test_glitch();
    test_bounce_fall();
    test_pending_race();
    test_reset_mid_count();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
